// File: rtl/mv_filter_multi.sv
// Multi-channel debounce/majority filter: per-channel saturating up/down vote
// counter with hysteresis thresholds, optional sticky level, and rise/fall pulses.
module mv_filter_multi #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned THRESH_HI = 10,
  parameter int unsigned THRESH_LO = 4,
  parameter int unsigned STICKY    = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      sample_i,
  input  logic [NUM_CH-1:0]         clear_i,
  input  logic [NUM_CH-1:0]         d_i,
  output logic [NUM_CH-1:0]         q_o,
  output logic [NUM_CH-1:0]         rise_o,
  output logic [NUM_CH-1:0]         fall_o,
  output logic [NUM_CH*WIDTH-1:0]   cnt_o
);

  if (NUM_CH == 0 || THRESH_LO >= THRESH_HI ||
      longint'(THRESH_HI) > ((longint'(1) << WIDTH) - longint'(1))) begin : g_param_err
    $fatal(1, "mv_filter_multi: illegal NUM_CH/WIDTH/THRESH_HI/THRESH_LO combination");
  end

  localparam logic [WIDTH-1:0] CNT_MAX   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] TH_HI     = WIDTH'(THRESH_HI);
  localparam logic [WIDTH-1:0] TH_LO     = WIDTH'(THRESH_LO);
  localparam logic             STICKY_EN = (STICKY != 0);

  logic [NUM_CH-1:0][WIDTH-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0]            q_q, q_d;
  logic [NUM_CH-1:0]            rise_q, rise_d;
  logic [NUM_CH-1:0]            fall_q, fall_d;

  // Level follows the counter's next value so a threshold crossing shows on the same edge.
  always_comb begin
    cnt_d = cnt_q;
    q_d   = q_q;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      if (clear_i[c]) begin
        cnt_d[c] = '0;
      end else if (sample_i) begin
        if (d_i[c]) begin
          if (cnt_q[c] != CNT_MAX) cnt_d[c] = cnt_q[c] + WIDTH'(1);
        end else begin
          if (cnt_q[c] != '0) cnt_d[c] = cnt_q[c] - WIDTH'(1);
        end
      end

      if (clear_i[c]) begin
        q_d[c] = 1'b0;
      end else if (cnt_d[c] >= TH_HI) begin
        q_d[c] = 1'b1;
      end else if (cnt_d[c] <= TH_LO) begin
        q_d[c] = STICKY_EN & q_q[c];
      end
    end
    rise_d = q_d & ~q_q;
    fall_d = ~q_d & q_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      q_q    <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      q_q    <= q_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign q_o    = q_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
  assign cnt_o  = cnt_q;

endmodule

// File: doc/mv_filter_multi.md
Name: mv_filter_multi

Overview:
- Multi-channel debounce/majority filter with a saturating up/down vote counter and hysteresis per channel.
- Each channel integrates a strobed binary input and produces a stable filtered level plus one-cycle rise/fall event pulses.
- Optional sticky mode: the output latches once set and only a clear releases it.
- Sits between asynchronous-origin status lines (already synchronised) and control logic such as interrupt sources, link-detect and fault flags.

Parameters:
- NUM_CH, 4: number of independent channels; at least 1.
- WIDTH, 4: counter width per channel; counter saturates at 2^WIDTH-1.
- THRESH_HI, 10: counter value at or above which q asserts; at most 2^WIDTH-1.
- THRESH_LO, 4: counter value at or below which q deasserts; must be less than THRESH_HI.
- STICKY, 0: 1 = q, once set, stays set until clear_i; the counter keeps running.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous active-high reset.
- sample_i  in  1  sample strobe shared by all channels; counters move only when high.
- clear_i  in  NUM_CH  per-channel synchronous clear.
- d_i  in  NUM_CH  raw per-channel input, valid when sample_i is high.
- q_o  out  NUM_CH  filtered level per channel.
- rise_o  out  NUM_CH  one-cycle pulse when q_o[c] goes 0->1.
- fall_o  out  NUM_CH  one-cycle pulse when q_o[c] goes 1->0.
- cnt_o  out  NUM_CH*WIDTH  per-channel counter value, channel c at bits [c*WIDTH +: WIDTH]; for debug and status.

Behaviour:
- Reset (rst_i high, asynchronous): all counters 0, q_o 0, rise_o 0, fall_o 0. This holds while rst_i is high. The first update occurs on the first rising edge after rst_i deasserts.
- Counter next value (per channel, priority order):
  - clear_i[c]: 0.
  - sample_i and d_i[c]: cnt+1, saturating at 2^WIDTH-1.
  - sample_i and !d_i[c]: cnt-1, saturating at 0.
  - Otherwise: hold.
- Level next value, computed from the counter next value (cnt_n) in the same cycle:
  - clear_i[c]: 0.
  - cnt_n >= THRESH_HI: 1.
  - cnt_n <= THRESH_LO: 0, unless STICKY=1 and q is already 1, in which case it stays 1.
  - Otherwise: hold (hysteresis band).
- Latency: a sample that moves the counter across a threshold changes q_o on that same clock edge. q_o is registered, so it is visible in the cycle after the strobe.
- rise_o[c] and fall_o[c] are registered, and assert in exactly the cycle where q_o[c] has just changed. Each lasts exactly one cycle and is never asserted simultaneously with the other on the same channel.
- clear_i[c] while q_o[c]=1: q_o drops and fall_o[c] pulses in the next cycle, in sticky and non-sticky modes alike.
- clear_i[c] together with sample_i: clear wins, and the sample is discarded for that channel only.
- Saturation: sustained 1s hold cnt at 2^WIDTH-1 with no wrap. Sustained 0s hold cnt at 0 with no underflow.
- Channels are fully independent; no cross-channel state.
- sample_i low: no counter or q change, except through clear_i.
- Elaboration check: fatal error if THRESH_LO >= THRESH_HI, THRESH_HI > 2^WIDTH-1, or NUM_CH = 0.
- Timing: no combinational path from inputs to outputs.

Test Plan:
All scenarios use NUM_CH=2, WIDTH=4, THRESH_HI=10, THRESH_LO=4, STICKY=0 unless stated.
- Reset mid-operation:
  - Stimulus: drive ch0 to cnt=12 with q_o=1, then pulse rst_i asynchronously between edges.
  - Required: q_o, cnt_o and rise_o/fall_o all 0 immediately; first sample after release gives cnt=1.
- Assert with hysteresis:
  - Stimulus: 10 strobes with d_i=2'b01.
  - Required: cnt0 reaches 10, q_o[0]=1 and rise_o[0]=1 in the cycle after the 10th strobe; ch1 stays cnt 0, q 0.
  - Then 5 strobes with d_i=0: cnt0=5, q_o[0] still 1. A 6th strobe gives cnt0=4, q_o[0]=0 and a single fall_o[0] pulse.
- Saturation:
  - Stimulus: 20 strobes of 1 on ch1.
  - Required: cnt1 stops at 15 with no wrap and exactly one rise_o[1] pulse.
  - Then 20 strobes of 0: cnt1 stops at 0 and exactly one fall_o[1] pulse.
- Clear priority:
  - Stimulus: ch0 at cnt 11, q 1; assert clear_i=2'b01 and sample_i with d_i=2'b11 in the same cycle.
  - Required: cnt0=0, q_o[0]=0, fall_o[0] pulses; ch1 increments to 1.
- Sticky mode (STICKY=1):
  - Stimulus: drive ch0 to 10, then 15 strobes of 0.
  - Required: cnt0=0 but q_o[0] stays 1 with no fall pulse; clear_i[0] then drops q_o[0] and pulses fall_o[0].
- Strobe gating:
  - Stimulus: d_i=2'b11 held for 30 cycles with sample_i low.
  - Required: counters and outputs unchanged; alternating sample_i every other cycle gives q_o=2'b11 after the 10th strobe.
